// File: rtl/sseg_scan_capture.sv
// Receive-side monitor for an active-low seven-segment scan bus: qualifies each
// segment/anode pattern for stability and decodes it back into per-digit hex values.
module sseg_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:6]  sseg_in,
  input  logic [3:0]  an_in,
  input  logic        clr,
  output logic [15:0] hex_out,
  output logic [3:0]  dig_valid,
  output logic        frame_done,
  output logic        bad_pattern
);

  localparam int unsigned  CW      = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [6:0]   BLANK   = 7'b1111111;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_COMMIT,
    ST_HOLD
  } state_t;

  // Internal segment vectors keep segment a in bit 6, so patterns read a..g left to right.
  logic [6:0]    seg_s1, seg_s2, seg_q;
  logic [3:0]    an_s1, an_s2, an_q;
  logic          same;
  logic [CW-1:0] cnt, cnt_inc;
  state_t        state, state_nx;
  logic          commit_en;
  logic [3:0]    an_sel;
  logic          one_hot;
  logic [4:0]    dec;
  logic [15:0]   hex_nx;
  logic [3:0]    valid_nx, seen, seen_nx;
  logic          bad_nx;

  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b0000001: r = {1'b1, 4'h0};
      7'b1001111: r = {1'b1, 4'h1};
      7'b0010010: r = {1'b1, 4'h2};
      7'b0000110: r = {1'b1, 4'h3};
      7'b1001100: r = {1'b1, 4'h4};
      7'b0100100: r = {1'b1, 4'h5};
      7'b0100000: r = {1'b1, 4'h6};
      7'b0001111: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0000100: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b1100000: r = {1'b1, 4'hB};
      7'b0110001: r = {1'b1, 4'hC};
      7'b1000010: r = {1'b1, 4'hD};
      7'b0110000: r = {1'b1, 4'hE};
      7'b0111000: r = {1'b1, 4'hF};
      default:    r = '0;
    endcase
    return r;
  endfunction

  // Two-flop synchronizers plus the previous-sample register; all idle-high on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      seg_q  <= '1;
      an_s1  <= '1;
      an_s2  <= '1;
      an_q   <= '1;
    end else begin
      seg_s1 <= sseg_in;
      seg_s2 <= seg_s1;
      seg_q  <= seg_s2;
      an_s1  <= an_in;
      an_s2  <= an_s1;
      an_q   <= an_s2;
    end
  end

  assign same    = (seg_s2 == seg_q) && (an_s2 == an_q);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!same) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_WAIT;
    end else begin
      state <= state_nx;
    end
  end

  // COMMIT re-checks stability so a pattern must survive one sample past qualification.
  always_comb begin
    state_nx  = state;
    commit_en = 1'b0;
    case (state)
      ST_WAIT: begin
        if (same && (cnt_inc == CNT_MAX)) state_nx = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (same) begin
          commit_en = 1'b1;
          state_nx  = ST_HOLD;
        end else begin
          state_nx  = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (!same) state_nx = ST_WAIT;
      end
      default: state_nx = ST_WAIT;
    endcase
  end

  assign an_sel  = ~an_q;
  assign one_hot = (an_sel != '0) && ((an_sel & (an_sel - 4'd1)) == '0);
  assign dec     = decode(seg_q);

  always_comb begin
    hex_nx   = hex_out;
    valid_nx = dig_valid;
    bad_nx   = bad_pattern;
    seen_nx  = (seen == 4'hF) ? '0 : seen;
    if (commit_en && one_hot) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (an_sel[i]) begin
          if (dec[4]) begin
            hex_nx[4*i +: 4] = dec[3:0];
            valid_nx[i]      = 1'b1;
            seen_nx[i]       = 1'b1;
          end else if (seg_q == BLANK) begin
            valid_nx[i] = 1'b0;
            seen_nx[i]  = 1'b1;
          end else begin
            valid_nx[i] = 1'b0;
            bad_nx      = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hex_out     <= '0;
      dig_valid   <= '0;
      bad_pattern <= 1'b0;
      seen        <= '0;
      frame_done  <= 1'b0;
    end else if (clr) begin
      hex_out     <= '0;
      dig_valid   <= '0;
      bad_pattern <= 1'b0;
      seen        <= '0;
      frame_done  <= 1'b0;
    end else begin
      hex_out     <= hex_nx;
      dig_valid   <= valid_nx;
      bad_pattern <= bad_nx;
      seen        <= seen_nx;
      frame_done  <= (seen == 4'hF);
    end
  end

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Self-checking bench for sseg_scan_capture: directed scenarios plus randomized
// scan traffic compared against a stability/commit reference model.
module tb_sseg_scan_capture;

  localparam int N = 4;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [6:0]  sseg_in = 7'b1111111;
  logic [3:0]  an_in = 4'hF;
  logic [15:0] hex_out;
  logic [3:0]  dig_valid;
  logic        frame_done;
  logic        bad_pattern;

  int checks = 0;
  int failures = 0;

  sseg_scan_capture #(.STABLE_CYCLES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .sseg_in    (sseg_in),
    .an_in      (an_in),
    .clr        (clr),
    .hex_out    (hex_out),
    .dig_valid  (dig_valid),
    .frame_done (frame_done),
    .bad_pattern(bad_pattern)
  );

  always #5 clk = ~clk;

  logic [6:0] pat_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model: a pattern held for N+1 edges commits 2 edges after qualifying.
  typedef struct {
    int         due;
    logic [3:0] an;
    logic [6:0] seg;
  } pend_t;

  pend_t       pend[$];
  pend_t       np;
  int          edge_no = 0;
  int          run = 0;
  bit          fresh = 1'b1;
  bit          fd_nx;
  logic [3:0]  cur_an = '1;
  logic [6:0]  cur_seg = '1;
  logic [15:0] m_hex = '0;
  logic [3:0]  m_valid = '0;
  logic [3:0]  m_mask = '0;
  logic        m_bad = 1'b0;
  logic        m_fd = 1'b0;

  function automatic int classify(input logic [6:0] p);
    for (int k = 0; k < 16; k++) if (pat_tab[k] == p) return k;
    if (p == BLANK) return 16;
    return -1;
  endfunction

  task automatic model_commit(input pend_t p);
    logic [3:0] sel;
    int d, k;
    sel = ~p.an;
    if ($countones(sel) != 1) return;
    d = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) d = i;
    k = classify(p.seg);
    if (k >= 0 && k < 16) begin
      m_hex[4*d +: 4] = 4'(k);
      m_valid[d] = 1'b1;
      m_mask[d]  = 1'b1;
    end else if (k == 16) begin
      m_valid[d] = 1'b0;
      m_mask[d]  = 1'b1;
    end else begin
      m_valid[d] = 1'b0;
      m_bad      = 1'b1;
    end
  endtask

  initial begin : model
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_hex = '0; m_valid = '0; m_mask = '0; m_bad = 1'b0; m_fd = 1'b0;
        pend.delete();
        run = 0;
        fresh = 1'b1;
      end else begin
        edge_no++;
        fd_nx = (m_mask == 4'hF);
        if (fd_nx) m_mask = '0;
        while (pend.size() > 0 && pend[0].due == edge_no) model_commit(pend.pop_front());
        if (clr) begin
          m_hex = '0; m_valid = '0; m_mask = '0; m_bad = 1'b0; fd_nx = 1'b0;
        end
        m_fd = fd_nx;
        if (fresh || an_in != cur_an || sseg_in != cur_seg) begin
          cur_an = an_in; cur_seg = sseg_in; run = 1; fresh = 1'b0;
        end else begin
          run++;
        end
        if (run == N + 1) begin
          np.due = edge_no + 2; np.an = cur_an; np.seg = cur_seg;
          pend.push_back(np);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0; clr = 1'b0; an_in = 4'hF; sseg_in = BLANK;
    repeat (2) @(negedge clk);
    checks++; if (hex_out !== 16'h0) begin failures++; $display("FAIL reset_hex got=%h exp=0000", hex_out); end
    checks++; if (dig_valid !== 4'h0) begin failures++; $display("FAIL reset_valid got=%b exp=0000", dig_valid); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b exp=0", frame_done); end
    checks++; if (bad_pattern !== 1'b0) begin failures++; $display("FAIL reset_bad got=%b exp=0", bad_pattern); end
    rst = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if (dig_valid !== 4'h0 || hex_out !== 16'h0) begin
      failures++; $display("FAIL idle_after_reset got=%b/%h exp=0000/0000", dig_valid, hex_out);
    end
  endtask

  task automatic test_scan();
    int fd_cnt, fd_at;
    fd_cnt = 0; fd_at = -1;
    for (int d = 0; d < 4; d++) begin
      an_in = ~(4'b0001 << d);
      sseg_in = pat_tab[d+1];
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (frame_done === 1'b1) begin fd_cnt++; fd_at = c + 10*d; end
        checks++; if (hex_out !== m_hex) begin failures++; $display("FAIL scan_model_hex got=%h exp=%h", hex_out, m_hex); end
      end
    end
    checks++; if (hex_out !== 16'h4321) begin failures++; $display("FAIL scan_hex got=%h exp=4321", hex_out); end
    checks++; if (dig_valid !== 4'hF) begin failures++; $display("FAIL scan_valid got=%b exp=1111", dig_valid); end
    checks++; if (bad_pattern !== 1'b0) begin failures++; $display("FAIL scan_bad got=%b exp=0", bad_pattern); end
    checks++; if (fd_cnt != 1) begin failures++; $display("FAIL scan_frame_count got=%0d exp=1", fd_cnt); end
    checks++; if (fd_at != 38) begin failures++; $display("FAIL scan_frame_cycle got=%0d exp=38", fd_at); end
  endtask

  task automatic test_hold_c();
    int changes;
    logic [15:0] last, exp;
    changes = 0; last = hex_out;
    an_in = 4'b1110; sseg_in = 7'b0110001;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      exp = (c >= 7) ? 16'h432C : 16'h4321;
      if (hex_out !== last) changes++;
      last = hex_out;
      checks++; if (hex_out !== exp) begin failures++; $display("FAIL hold_c_hex cycle=%0d got=%h exp=%h", c, hex_out, exp); end
    end
    checks++; if (changes != 1) begin failures++; $display("FAIL hold_c_changes got=%0d exp=1", changes); end
    checks++; if (dig_valid !== 4'hF) begin failures++; $display("FAIL hold_c_valid got=%b exp=1111", dig_valid); end
  endtask

  task automatic test_glitch();
    sseg_in = 7'b0000000;
    repeat (N) begin
      @(negedge clk);
      checks++; if (hex_out !== 16'h432C) begin failures++; $display("FAIL glitch_hex got=%h exp=432c", hex_out); end
    end
    sseg_in = 7'b0110001;
    repeat (12) begin
      @(negedge clk);
      checks++; if (hex_out !== 16'h432C) begin failures++; $display("FAIL glitch_after_hex got=%h exp=432c", hex_out); end
    end
  endtask

  task automatic test_anodes();
    for (int phase = 0; phase < 2; phase++) begin
      an_in = (phase == 0) ? 4'b1100 : 4'b1111;
      sseg_in = pat_tab[5];
      repeat (20) begin
        @(negedge clk);
        checks++; if (hex_out !== 16'h432C || dig_valid !== 4'hF || frame_done !== 1'b0 || bad_pattern !== 1'b0) begin
          failures++; $display("FAIL anodes_%0d got=%h/%b/%b/%b exp=432c/1111/0/0", phase, hex_out, dig_valid, frame_done, bad_pattern);
        end
      end
    end
  endtask

  task automatic test_bad();
    an_in = 4'b1011; sseg_in = 7'b1010101;
    repeat (10) @(negedge clk);
    checks++; if (dig_valid !== 4'b1011) begin failures++; $display("FAIL bad_valid got=%b exp=1011", dig_valid); end
    checks++; if (bad_pattern !== 1'b1) begin failures++; $display("FAIL bad_flag got=%b exp=1", bad_pattern); end
    checks++; if (hex_out !== 16'h432C) begin failures++; $display("FAIL bad_hex got=%h exp=432c", hex_out); end
    for (int d = 0; d < 4; d++) begin
      an_in = ~(4'b0001 << d);
      sseg_in = pat_tab[d+5];
      repeat (10) @(negedge clk);
    end
    checks++; if (hex_out !== 16'h8765) begin failures++; $display("FAIL bad_frame_hex got=%h exp=8765", hex_out); end
    checks++; if (dig_valid !== 4'hF) begin failures++; $display("FAIL bad_frame_valid got=%b exp=1111", dig_valid); end
    checks++; if (bad_pattern !== 1'b1) begin failures++; $display("FAIL bad_sticky got=%b exp=1", bad_pattern); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (hex_out !== 16'h0 || dig_valid !== 4'h0 || bad_pattern !== 1'b0 || frame_done !== 1'b0) begin
      failures++; $display("FAIL clr_outputs got=%h/%b/%b/%b exp=0000/0000/0/0", hex_out, dig_valid, bad_pattern, frame_done);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] eh;
    logic [3:0]  ev;
    an_in = 4'b1101; sseg_in = pat_tab[9];
    repeat (10) @(negedge clk);
    checks++; if (hex_out !== 16'h0090 || dig_valid !== 4'b0010) begin
      failures++; $display("FAIL pre_reset got=%h/%b exp=0090/0010", hex_out, dig_valid);
    end
    an_in = 4'b1110; sseg_in = pat_tab[5];
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (hex_out !== 16'h0 || dig_valid !== 4'h0 || bad_pattern !== 1'b0 || frame_done !== 1'b0) begin
      failures++; $display("FAIL async_reset got=%h/%b/%b/%b exp=0000/0000/0/0", hex_out, dig_valid, bad_pattern, frame_done);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      eh = (c >= 7) ? 16'h0005 : 16'h0000;
      ev = (c >= 7) ? 4'b0001 : 4'b0000;
      checks++; if (hex_out !== eh || dig_valid !== ev) begin
        failures++; $display("FAIL requalify cycle=%0d got=%h/%b exp=%h/%b", c, hex_out, dig_valid, eh, ev);
      end
    end
  endtask

  task automatic test_random();
    int hold, sel;
    for (int s = 0; s < 250; s++) begin
      sel = int'($urandom_range(0, 9));
      case ($urandom_range(0, 4))
        0, 1, 2: an_in = ~(4'b0001 << $urandom_range(0, 3));
        default: an_in = 4'($urandom);
      endcase
      if (sel < 6)       sseg_in = pat_tab[$urandom_range(0, 15)];
      else if (sel == 6) sseg_in = BLANK;
      else               sseg_in = 7'($urandom);
      hold = int'($urandom_range(1, 12));
      repeat (hold) begin
        clr = ($urandom_range(0, 39) == 0);
        @(negedge clk);
        checks++; if (hex_out !== m_hex) begin failures++; $display("FAIL rand_hex seg=%0d got=%h exp=%h", s, hex_out, m_hex); end
        checks++; if (dig_valid !== m_valid) begin failures++; $display("FAIL rand_valid seg=%0d got=%b exp=%b", s, dig_valid, m_valid); end
        checks++; if (bad_pattern !== m_bad) begin failures++; $display("FAIL rand_bad seg=%0d got=%b exp=%b", s, bad_pattern, m_bad); end
        checks++; if (frame_done !== m_fd) begin failures++; $display("FAIL rand_frame seg=%0d got=%b exp=%b", s, frame_done, m_fd); end
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hold_c();
    test_glitch();
    test_anodes();
    test_bad();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
